tick_sched: RTL and testbench
=============================

Name: tick_sched

Overview:
- Shared-timebase timer scheduler for the CPU's slow peripherals (display scan, key debounce, LED blink).
- Contains one prescaler that produces a single-cycle timebase tick every DIV clocks.
- Multiplexes NCH independent programmable countdown channels onto that tick.
- Funnels channel expirations through a round-robin arbiter onto one valid/ack event interface for the controller.

Parameters:
- DIV, 100000, prescaler period in clk cycles (>=2); tick pulses once per DIV cycles.
- NCH, 4, number of timer channels (power of 2, 2..8).
- CHW, 2, channel index width, log2(NCH).
- CW, 16, period/remaining counter width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- cmd_valid  input  1  command strobe, one cycle per command, always accepted
- cmd_ch  input  CHW  target channel
- cmd_op  input  2  00 nop, 01 start one-shot, 10 start periodic, 11 stop
- cmd_period  input  CW  period in ticks, sampled on start ops
- tick  output  1  registered prescaler pulse
- active  output  NCH  per-channel running flag
- ovf  output  NCH  sticky per-channel overrun flag
- evt_valid  output  1  an expiration event is presented
- evt_ch  output  CHW  channel of presented event; stable while evt_valid
- evt_ack  input  1  consumer accepts presented event

Behaviour:
- Reset (async): all outputs 0 — tick, active, ovf, evt_valid, evt_ch. Internal state also 0: prescaler count, rem[], period[], mode[], pend[], rr pointer.
- Prescaler, each clk edge:
  - if count==DIV-1: count<=0, tick<=1; else count<=count+1, tick<=0.
  - First tick is high after the DIV-th edge following reset release; thereafter exactly one high cycle every DIV cycles.
- Channel command (cmd_valid=1, applies to cmd_ch only, takes effect next edge):
  - start (01/10), cmd_period!=0: period<=cmd_period, rem<=cmd_period, mode<=periodic?1:0, active<=1, ovf[ch]<=0. pend[ch] is unchanged.
  - start with cmd_period==0: behaves exactly as stop.
  - stop: active<=0. pend and ovf are unchanged.
  - Restarting an active channel reloads it immediately.
- Channel countdown: on a cycle with tick=1 for each active channel:
  - rem>1: rem<=rem-1.
  - rem==1: expire. pend<=1. If periodic, rem<=period; else active<=0.
  - A period of P ticks therefore expires on the P-th tick after start.
- Simultaneous command and tick on the same channel: the command wins and that channel's tick is ignored. Other channels count normally.
- Overrun: an expiration while pend[ch] is already 1 (and not being acked that cycle) sets ovf[ch]<=1. pend stays 1; events are not queued.
- Arbiter:
  - When evt_valid=0 and any pend bit is set, select the first set bit searching from rr+1 upward with wrap-around.
  - Next edge: evt_valid<=1, evt_ch<=selected, rr<=selected.
  - evt_valid and evt_ch hold until evt_ack=1 while evt_valid=1.
  - On ack: pend[evt_ch]<=0 and evt_valid<=0 next edge. Minimum one idle cycle between events.
  - evt_ack while evt_valid=0 is ignored.
  - Expire on the same channel in its ack cycle: pend stays 1, ovf is not set, and the channel is re-eligible.
- Reset mid-operation: everything returns to reset values immediately. Pending events are discarded.

Test Plan:
- DIV=4, release reset, no commands -> tick high after edges 4, 8, 12…, exactly 1 cycle each; all other outputs stay 0.
- DIV=4, start one-shot ch1 period=3 -> expiry on 3rd tick; active[1] falls; evt_valid=1, evt_ch=1 next cycle; held 5 cycles with no ack; ack -> evt_valid=0 next cycle, no further events.
- DIV=4, start periodic ch0 period=2, ack every event within 2 cycles -> events every 8 clk indefinitely; ovf[0] stays 0; stop -> active[0]=0, no more events.
- Periodic ch2 period=1, never ack -> second expiry sets ovf[2]=1; evt_ch stays 2; restarting ch2 clears ovf[2].
- Ch0, ch1, ch3 all expire on the same tick, acks immediate -> evt_ch sequence 0,1,3 with one idle cycle between events; a later simultaneous expiry of ch0 and ch3 yields 0 then 3 (rr from 3 wraps to 0).
- Start ch0 command coincident with a tick, then assert reset while evt_valid=1 -> command reload wins (rem=period, no decrement); reset drives evt_valid, active, ovf to 0 asynchronously, and the first tick comes DIV edges after release.

Source files
------------

// File: rtl/tick_sched.sv
// tick_sched: shared-timebase timer scheduler.
// One prescaler produces a single-cycle tick every DIV clocks. NCH countdown
// channels run off that tick. Their expirations are funnelled through a
// round-robin arbiter onto a single valid/ack event interface.
//
// Arbiter states
//   state    | meaning
//   ARB_IDLE | no event presented; loads the next pending channel if any
//   ARB_EVT  | event presented on evt_ch, held until evt_ack
module tick_sched #(
  parameter int DIV = 100000,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  input  logic [CHW-1:0] cmd_ch,
  input  logic [1:0]     cmd_op,
  input  logic [CW-1:0]  cmd_period,
  output logic           tick,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] ovf,
  output logic           evt_valid,
  output logic [CHW-1:0] evt_ch,
  input  logic           evt_ack
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_EVT  = 1'b1
  } arb_state_t;

  arb_state_t     arb_state;
  arb_state_t     arb_next;
  logic           load_evt;

  logic [PW-1:0]  pre_cnt;
  logic [CW-1:0]  rem_q [NCH];
  logic [CW-1:0]  per_q [NCH];
  logic [NCH-1:0] mode_q;
  logic [NCH-1:0] pend_q;
  logic [CHW-1:0] rr_q;

  logic           cmd_start;
  logic [NCH-1:0] cmd_hit;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] ack_clr;
  logic [CHW-1:0] sel_ch;
  logic [CHW-1:0] sel_idx;

  assign evt_valid = (arb_state == ARB_EVT);
  assign cmd_start = (cmd_op == 2'b01) || (cmd_op == 2'b10);

  // Prescaler: wraps at DIV-1 and emits a registered one-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PW'(DIV - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  // Per-channel decode: command hit, tick-driven expiry and ack clear.
  // A command on a channel masks that channel's tick for the same cycle.
  always_comb begin
    cmd_hit = '0;
    expire  = '0;
    ack_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      cmd_hit[i] = cmd_valid && (cmd_ch == CHW'(i)) && (cmd_op != 2'b00);
      expire[i]  = tick && active[i] && !cmd_hit[i] && (rem_q[i] <= CW'(1));
      ack_clr[i] = evt_valid && evt_ack && (evt_ch == CHW'(i));
    end
  end

  // Channel state: reload on start, countdown on tick, pending/overrun flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        rem_q[i] <= '0;
        per_q[i] <= '0;
      end
      mode_q <= '0;
      active <= '0;
      ovf    <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cmd_hit[i]) begin
          // A zero-period start is treated as a stop.
          if (cmd_start && (cmd_period != '0)) begin
            per_q[i]  <= cmd_period;
            rem_q[i]  <= cmd_period;
            mode_q[i] <= (cmd_op == 2'b10);
            active[i] <= 1'b1;
            ovf[i]    <= 1'b0;
          end else begin
            active[i] <= 1'b0;
          end
        end else if (tick && active[i]) begin
          if (expire[i]) begin
            if (mode_q[i]) rem_q[i] <= per_q[i];
            else           active[i] <= 1'b0;
          end else begin
            rem_q[i] <= rem_q[i] - CW'(1);
          end
        end

        // An expiry in the ack cycle re-arms pend without flagging overrun.
        if (expire[i]) begin
          pend_q[i] <= 1'b1;
          if (pend_q[i] && !ack_clr[i]) ovf[i] <= 1'b1;
        end else if (ack_clr[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pick: first pending channel after rr, wrapping; rr itself last.
  always_comb begin
    sel_ch  = rr_q;
    sel_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      sel_idx = rr_q + CHW'(k);
      if (pend_q[sel_idx]) sel_ch = sel_idx;
    end
  end

  // Arbiter next-state: present a pending event, hold it until acked.
  always_comb begin
    arb_next = arb_state;
    load_evt = 1'b0;
    unique case (arb_state)
      ARB_IDLE: begin
        if (|pend_q) begin
          arb_next = ARB_EVT;
          load_evt = 1'b1;
        end
      end
      ARB_EVT: begin
        if (evt_ack) arb_next = ARB_IDLE;
      end
      default: arb_next = ARB_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) arb_state <= ARB_IDLE;
    else       arb_state <= arb_next;
  end

  // Latch the granted channel and advance the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_ch <= '0;
      rr_q   <= '0;
    end else if (load_evt) begin
      evt_ch <= sel_ch;
      rr_q   <= sel_ch;
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scenarios followed by a randomized phase, every
// cycle compared against a tick/countdown/arbiter reference model.
module tb_tick_sched;

  localparam int DIV = 4;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic [CHW-1:0] cmd_ch;
  logic [1:0]     cmd_op;
  logic [CW-1:0]  cmd_period;
  logic           tick;
  logic [NCH-1:0] active;
  logic [NCH-1:0] ovf;
  logic           evt_valid;
  logic [CHW-1:0] evt_ch;
  logic           evt_ack;

  tick_sched #(.DIV(DIV), .NCH(NCH), .CHW(CHW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ch     (cmd_ch),
    .cmd_op     (cmd_op),
    .cmd_period (cmd_period),
    .tick       (tick),
    .active     (active),
    .ovf        (ovf),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ack    (evt_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_cnt;
  bit           m_tick;
  int           m_rem [NCH];
  int           m_per [NCH];
  bit [NCH-1:0] m_mode;
  bit [NCH-1:0] m_act;
  bit [NCH-1:0] m_pend;
  bit [NCH-1:0] m_ovf;
  bit           m_ev;
  int           m_evch;
  int           m_rr;

  int got [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_tick = 0;
    for (int i = 0; i < NCH; i++) begin
      m_rem[i] = 0;
      m_per[i] = 0;
    end
    m_mode = '0;
    m_act  = '0;
    m_pend = '0;
    m_ovf  = '0;
    m_ev   = 0;
    m_evch = 0;
    m_rr   = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled,
  // then clock the DUT and compare all outputs.
  task automatic step();
    bit [NCH-1:0] ackc;
    bit n_ev;
    int n_evch;
    int n_rr;
    bit expd;
    int c;
    if (reset) begin
      model_reset();
    end else begin
      ackc = '0;
      if (m_ev && evt_ack) ackc[m_evch] = 1'b1;
      n_ev = m_ev; n_evch = m_evch; n_rr = m_rr;
      if (m_ev) begin
        if (evt_ack) n_ev = 0;
      end else if (m_pend != 0) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (m_pend[c]) begin
            n_ev = 1; n_evch = c; n_rr = c;
            break;
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        expd = 0;
        if (cmd_valid && int'(cmd_ch) == i && cmd_op != 2'b00) begin
          if ((cmd_op == 2'b01 || cmd_op == 2'b10) && cmd_period != 0) begin
            m_per[i]  = int'(cmd_period);
            m_rem[i]  = int'(cmd_period);
            m_mode[i] = (cmd_op == 2'b10);
            m_act[i]  = 1;
            m_ovf[i]  = 0;
          end else begin
            m_act[i] = 0;
          end
        end else if (m_tick && m_act[i]) begin
          if (m_rem[i] > 1) m_rem[i] = m_rem[i] - 1;
          else begin
            expd = 1;
            if (m_mode[i]) m_rem[i] = m_per[i];
            else           m_act[i] = 0;
          end
        end
        if (expd) begin
          if (m_pend[i] && !ackc[i]) m_ovf[i] = 1;
          m_pend[i] = 1;
        end else if (ackc[i]) begin
          m_pend[i] = 0;
        end
      end
      m_ev = n_ev; m_evch = n_evch; m_rr = n_rr;
      m_tick = (m_cnt == DIV - 1);
      m_cnt  = (m_cnt + 1) % DIV;
    end
    @(posedge clk);
    #1;
    check("tick",      32'(tick),      32'(m_tick));
    check("active",    32'(active),    32'(m_act));
    check("ovf",       32'(ovf),       32'(m_ovf));
    check("evt_valid", 32'(evt_valid), 32'(m_ev));
    check("evt_ch",    32'(evt_ch),    32'(m_evch));
  endtask

  task automatic issue(input int ch, input logic [1:0] op, input int per);
    cmd_valid  = 1'b1;
    cmd_ch     = CHW'(ch);
    cmd_op     = op;
    cmd_period = CW'(per);
    step();
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
  endtask

  task automatic wait_evt(input int budget);
    int b = budget;
    while (!evt_valid && b > 0) begin
      step();
      b--;
    end
    check("wait_evt_in_budget", 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_tick(input int budget);
    int b = budget;
    while (!tick && b > 0) begin
      step();
      b--;
    end
    check("wait_tick_in_budget", 32'(tick), 32'd1);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      evt_ack = evt_valid;
      step();
    end
    evt_ack = 1'b0;
  endtask

  // Ack every event immediately and record the channel order.
  task automatic collect(input int n, input int budget);
    int b = budget;
    int idx = 0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    while (idx < n && b > 0) begin
      evt_ack = evt_valid;
      step();
      b--;
      if (evt_valid) begin
        got[idx] = int'(evt_ch);
        idx++;
      end
    end
    check("collect_in_budget", 32'(idx), 32'(n));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tick"},      32'(tick),      32'd0);
    check({tag, "_active"},    32'(active),    32'd0);
    check({tag, "_ovf"},       32'(ovf),       32'd0);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_evt_ch"},    32'(evt_ch),    32'd0);
  endtask

  initial begin
    int nt;
    int ev_cnt;
    bit prev_v;

    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = 2'b00;
    cmd_period = '0; evt_ack = 1'b0;
    model_reset();
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle prescaler: ticks after edges 4, 8, 12
    nt = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check("idle_tick_phase", 32'(tick), 32'((c % DIV) == 0));
      if (tick) nt++;
    end
    check("idle_tick_count", 32'(nt), 32'd3);

    // One-shot ch1, period 3
    issue(1, 2'b01, 3);
    wait_evt(60);
    check("oneshot_evt_ch", 32'(evt_ch), 32'd1);
    check("oneshot_active_fell", 32'(active[1]), 32'd0);
    repeat (5) step();
    check("oneshot_hold", 32'(evt_valid), 32'd1);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    check("oneshot_acked", 32'(evt_valid), 32'd0);
    repeat (20) step();
    check("oneshot_no_more", 32'(evt_valid), 32'd0);

    // Periodic ch0, period 2, acked promptly
    issue(0, 2'b10, 2);
    ev_cnt = 0; prev_v = 0;
    repeat (64) begin
      evt_ack = evt_valid;
      step();
      if (evt_valid && !prev_v) ev_cnt++;
      prev_v = evt_valid;
    end
    evt_ack = 1'b0;
    check("periodic_event_count", 32'(ev_cnt >= 7 && ev_cnt <= 8), 32'd1);
    check("periodic_no_ovf", 32'(ovf[0]), 32'd0);
    issue(0, 2'b11, 0);
    check("periodic_stopped", 32'(active[0]), 32'd0);
    drain(24);
    check("periodic_quiet", 32'(evt_valid), 32'd0);

    // Periodic ch2, period 1, never acked -> overrun
    issue(2, 2'b10, 1);
    repeat (20) step();
    check("ovr_flag", 32'(ovf[2]), 32'd1);
    check("ovr_evt_ch", 32'(evt_ch), 32'd2);
    issue(2, 2'b10, 1);
    check("ovr_cleared_by_restart", 32'(ovf[2]), 32'd0);
    issue(2, 2'b11, 0);
    drain(20);

    // Park rr on ch3, then simultaneous expiry of ch0, ch1, ch3
    issue(3, 2'b01, 1);
    drain(20);
    wait_tick(20);
    issue(0, 2'b01, 2);
    issue(1, 2'b01, 2);
    issue(3, 2'b01, 2);
    collect(3, 80);
    check("rr_seq0", 32'(got[0]), 32'd0);
    check("rr_seq1", 32'(got[1]), 32'd1);
    check("rr_seq2", 32'(got[2]), 32'd3);
    drain(4);
    wait_tick(20);
    issue(0, 2'b01, 2);
    issue(3, 2'b01, 2);
    collect(2, 80);
    check("rr_wrap0", 32'(got[0]), 32'd0);
    check("rr_wrap1", 32'(got[1]), 32'd3);
    drain(4);

    // Start coincident with tick, then reset while an event is presented
    wait_tick(20);
    issue(0, 2'b01, 2);
    wait_evt(40);
    check("coincide_evt_ch", 32'(evt_ch), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= DIV + 1; c++) begin
      step();
      check("post_reset_first_tick", 32'(tick), 32'(c == DIV));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cmd_valid  = ($urandom_range(0, 5) == 0);
      cmd_ch     = CHW'($urandom_range(0, NCH - 1));
      cmd_op     = 2'($urandom_range(0, 3));
      cmd_period = CW'($urandom_range(0, 6));
      evt_ack    = ($urandom_range(0, 2) == 0);
      reset      = (n == 1500);
      step();
    end
    reset = 1'b0; cmd_valid = 1'b0; evt_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
